// File: rtl/pipeline_pkg.sv
// Shared types for the issue stage: FSM states and register index type.
package pipeline_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        CALL,
        WAIT
    } issue_state_t;

endpackage

// File: rtl/scoreboard_counters.sv
// Per-register pending-write counters. x0 is never tracked and always reads idle.
module scoreboard_counters
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     inc_en,
    input  reg_idx_t inc_idx,
    input  logic     dec_en,
    input  reg_idx_t dec_idx,
    input  reg_idx_t rd1_idx,
    input  reg_idx_t rd2_idx,
    output logic     rd1_busy,
    output logic     rd2_busy,
    output logic     inc_full,
    output logic     dec_empty
);

    logic [CNT_WIDTH-1:0] pend_q [NUM_REGS];
    logic [CNT_WIDTH-1:0] pend_d [NUM_REGS];

    // Next counter values; a same-cycle increment and decrement cancel out.
    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            pend_d[i] = pend_q[i];
            if (i != 0) begin
                if (inc_en && (inc_idx == reg_idx_t'(i)) &&
                    !(dec_en && (dec_idx == reg_idx_t'(i)))) begin
                    pend_d[i] = pend_q[i] + CNT_WIDTH'(1);
                end else if (dec_en && (dec_idx == reg_idx_t'(i)) &&
                             !(inc_en && (inc_idx == reg_idx_t'(i)))) begin
                    pend_d[i] = pend_q[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

    // Counter array state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

    // Read ports: busy flags for sources, saturation / empty for the update indices.
    always_comb begin
        rd1_busy  = (rd1_idx != REG_X0) && (pend_q[rd1_idx] != '0);
        rd2_busy  = (rd2_idx != REG_X0) && (pend_q[rd2_idx] != '0);
        inc_full  = (pend_q[inc_idx] == '1);
        dec_empty = (pend_q[dec_idx] == '0);
    end

endmodule

// File: rtl/pipeline_issue_scoreboard.sv
// Issue controller: RAW hazard stalls, in-flight cap and ECALL serialisation.
module pipeline_issue_scoreboard
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned CNT_WIDTH    = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec_valid,
    input  logic [4:0] dec_r1,
    input  logic [4:0] dec_r2,
    input  logic       dec_uses_r1,
    input  logic       dec_uses_r2,
    input  logic [4:0] dec_dst,
    input  logic       dec_ecall,
    output logic       dec_ready,
    input  logic       ex_ready,
    output logic       issue_valid,
    input  logic       wb_valid,
    input  logic [4:0] wb_dst,
    input  logic       flush,
    output logic       ecall_req,
    input  logic       ecall_done,
    output logic       sb_error
);

    localparam int unsigned INFLIGHT_W = $clog2(MAX_INFLIGHT + 1);

    issue_state_t          state_q;
    logic                  ecall_req_q;
    logic                  sb_error_q, sb_error_d;
    logic [INFLIGHT_W-1:0] inflight_q, inflight_d;

    logic rd1_busy, rd2_busy, dst_full, wb_empty;
    logic issue_ok, retire_err, retire_ok, ready_st;

    scoreboard_counters #(
        .NUM_REGS  (NUM_REGS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counters (
        .clk       (clk),
        .reset     (reset),
        .inc_en    (issue_valid && (dec_dst != REG_X0)),
        .inc_idx   (dec_dst),
        .dec_en    (retire_ok && (wb_dst != REG_X0)),
        .dec_idx   (wb_dst),
        .rd1_idx   (dec_r1),
        .rd2_idx   (dec_r2),
        .rd1_busy  (rd1_busy),
        .rd2_busy  (rd2_busy),
        .inc_full  (dst_full),
        .dec_empty (wb_empty)
    );

    // Issue decision and retire classification; a bad retire changes no counter.
    always_comb begin
        issue_ok = dec_valid && (state_q == RUN) && !flush && !dec_ecall && ex_ready &&
                   !(dec_uses_r1 && rd1_busy) && !(dec_uses_r2 && rd2_busy) &&
                   (inflight_q < INFLIGHT_W'(MAX_INFLIGHT)) &&
                   !((dec_dst != REG_X0) && dst_full);
        retire_err = wb_valid && (((wb_dst != REG_X0) && wb_empty) || (inflight_q == '0));
        retire_ok  = wb_valid && !retire_err;
    end

    // Decode handshake per state; reset forces ready high and issue low.
    always_comb begin
        ready_st = 1'b0;
        case (state_q)
            RUN:     ready_st = !dec_valid || issue_ok || flush;
            DRAIN:   ready_st = flush;
            CALL:    ready_st = 1'b0;
            WAIT:    ready_st = ecall_done;
            default: ready_st = 1'b0;
        endcase
    end

    assign issue_valid = reset && issue_ok;
    assign dec_ready   = !reset || ready_st;
    assign ecall_req   = ecall_req_q;
    assign sb_error    = sb_error_q;

    // In-flight count and sticky error next-state.
    always_comb begin
        inflight_d = inflight_q;
        if (issue_valid && !retire_ok) begin
            inflight_d = inflight_q + INFLIGHT_W'(1);
        end else if (!issue_valid && retire_ok) begin
            inflight_d = inflight_q - INFLIGHT_W'(1);
        end
        sb_error_d = sb_error_q || retire_err;
    end

    // In-flight counter and error flag state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= '0;
            sb_error_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            sb_error_q <= sb_error_d;
        end
    end

    // ECALL FSM with registered request pulse; drain ends on the cycle the last retire lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            ecall_req_q <= 1'b0;
        end else begin
            ecall_req_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (dec_valid && dec_ecall && !flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        state_q <= RUN;
                    end else if (inflight_d == '0) begin
                        state_q     <= CALL;
                        ecall_req_q <= 1'b1;
                    end
                end
                CALL: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (ecall_done) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

endmodule
